// File: rtl/vga_embarcacao_desenho_if.sv
// vga_embarcacao_desenho_if
// Bundles every signal between the ship-board drawer and its environment.
//   posicoesEmbarcacao : 8 slots x 8 bits, slot k = [8k+7:8k], [3:0]=X, [7:4]=Y
//   pos_valid/pos_ready: vector handshake
//   frame_start        : one-cycle pulse at start of vertical blanking
//   pixel_x/pixel_y    : current scan position, video_on qualifies it
//   rgb/ship_px        : pixel result, 2 cycles after the scan position
//   dup_err/swap_done  : status
//   fsm_state          : current vector-loader state, for observation only
//
// Handshake: a vector is transferred on a rising clock edge where
// pos_valid and pos_ready are both high. The source must hold the vector
// stable while pos_valid is high and pos_ready is low. pos_ready depends
// only on internal state, never combinationally on pos_valid.
interface vga_embarcacao_desenho_if;
  logic [63:0] posicoesEmbarcacao;
  logic        pos_valid;
  logic        pos_ready;
  logic        frame_start;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic [7:0]  rgb;
  logic        ship_px;
  logic        dup_err;
  logic        swap_done;
  logic [1:0]  fsm_state;

  modport master (
    output posicoesEmbarcacao, pos_valid, frame_start, pixel_x, pixel_y, video_on,
    input  pos_ready, rgb, ship_px, dup_err, swap_done, fsm_state
  );

  modport slave (
    input  posicoesEmbarcacao, pos_valid, frame_start, pixel_x, pixel_y, video_on,
    output pos_ready, rgb, ship_px, dup_err, swap_done, fsm_state
  );
endinterface

// File: rtl/vga_embarcacao_desenho.sv
// vga_embarcacao_desenho
// Accepts a packed 8-slot ship-position vector, expands it one slot per
// cycle into a 10x10 shadow bitmap, and copies the shadow into the display
// bitmap at the next frame_start. A 2-stage pixel pipeline colours each
// scan position as ship, water, grid line or black.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : vga_embarcacao_desenho_if.slave (vector handshake, scan
//           position in, colour and status out, FSM state for observation)
module vga_embarcacao_desenho #(
  parameter int         BOARD_X0  = 160,
  parameter int         BOARD_Y0  = 80,
  parameter int         CELL_LOG2 = 5,
  parameter logic [7:0] SHIP_RGB  = 8'hE0,
  parameter logic [7:0] WATER_RGB = 8'h03,
  parameter logic [7:0] GRID_RGB  = 8'hFF
) (
  input logic                     clk,
  input logic                     reset,
  vga_embarcacao_desenho_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUILD     = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  slot_q, slot_d;
  logic [63:0] vec_q, vec_d;
  logic [99:0] shadow_q, shadow_d;
  logic [99:0] display_q, display_d;
  logic        dup_q, dup_d;
  logic        swap_q, swap_d;

  // Current slot decode. Cells are stored row-major: index = (Y-1)*10 + (X-1).
  logic [7:0] slot_byte;
  logic [3:0] slot_x, slot_y;
  logic       slot_ok;
  logic [6:0] slot_idx;

  assign slot_byte = vec_q[{slot_q, 3'b000} +: 8];
  assign slot_x    = slot_byte[3:0];
  assign slot_y    = slot_byte[7:4];
  // Zero marks an unused slot, 11..15 is out of range; both are skipped.
  assign slot_ok   = (slot_x != 4'd0) && (slot_y != 4'd0) &&
                     (slot_x <= 4'd10) && (slot_y <= 4'd10);
  assign slot_idx  = ({3'b000, slot_y} - 7'd1) * 7'd10 + {3'b000, slot_x} - 7'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      slot_q    <= 3'd0;
      vec_q     <= 64'd0;
      shadow_q  <= 100'd0;
      display_q <= 100'd0;
      dup_q     <= 1'b0;
      swap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      vec_q     <= vec_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      dup_q     <= dup_d;
      swap_q    <= swap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    vec_d     = vec_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    dup_d     = dup_q;
    swap_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.pos_valid) begin
          vec_d    = bus.posicoesEmbarcacao;
          shadow_d = 100'd0;
          dup_d    = 1'b0;
          slot_d   = 3'd0;
          state_d  = ST_BUILD;
        end
      end
      ST_BUILD: begin
        if (slot_ok) begin
          // Only earlier slots of this vector can have set the bit.
          if (shadow_q[slot_idx]) dup_d = 1'b1;
          shadow_d[slot_idx] = 1'b1;
        end
        slot_d = slot_q + 3'd1;
        if (slot_q == 3'd7) state_d = ST_WAIT_SWAP;
      end
      ST_WAIT_SWAP: begin
        // A frame_start coinciding with the entry edge was sampled in BUILD
        // and is therefore ignored; the swap waits for the next pulse.
        if (bus.frame_start) begin
          display_d = shadow_q;
          swap_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.pos_ready = (state_q == ST_IDLE);
  assign bus.dup_err   = dup_q;
  assign bus.swap_done = swap_q;
  assign bus.fsm_state = state_q;

  // Pixel stage 1: board-relative offsets. Bit 10 is the sign, so any
  // position left of / above the board shows up as negative.
  logic [10:0] dx, dy;
  logic [9:0]  col_full, row_full;
  logic        on_board_c, edge_c;

  assign dx         = {1'b0, bus.pixel_x} - 11'(BOARD_X0);
  assign dy         = {1'b0, bus.pixel_y} - 11'(BOARD_Y0);
  assign col_full   = dx[9:0] >> CELL_LOG2;
  assign row_full   = dy[9:0] >> CELL_LOG2;
  assign on_board_c = !dx[10] && !dy[10] && (col_full < 10'd10) && (row_full < 10'd10);
  // Only the top/left pixel of each cell is a grid line, so the board has
  // no closing line on its right and bottom edges.
  assign edge_c     = (dx[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '0);

  logic [3:0] s1_col_q, s1_row_q;
  logic       s1_on_q, s1_edge_q, s1_vid_q;
  logic [7:0] rgb_q, rgb_d;
  logic       ship_q, ship_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_col_q  <= 4'd0;
      s1_row_q  <= 4'd0;
      s1_on_q   <= 1'b0;
      s1_edge_q <= 1'b0;
      s1_vid_q  <= 1'b0;
      rgb_q     <= 8'd0;
      ship_q    <= 1'b0;
    end else begin
      s1_col_q  <= col_full[3:0];
      s1_row_q  <= row_full[3:0];
      s1_on_q   <= on_board_c;
      s1_edge_q <= edge_c;
      s1_vid_q  <= bus.video_on;
      rgb_q     <= rgb_d;
      ship_q    <= ship_d;
    end
  end

  // Pixel stage 2: colour priority. The cell lookup is only meaningful on
  // the board, so it is gated by s1_on_q.
  logic [6:0] cell_idx;
  logic       cell_hit;

  assign cell_idx = {3'b000, s1_row_q} * 7'd10 + {3'b000, s1_col_q};
  assign cell_hit = s1_on_q && display_q[cell_idx];

  always_comb begin
    rgb_d  = 8'd0;
    ship_d = s1_vid_q && cell_hit;
    if (!s1_vid_q)      rgb_d = 8'd0;
    else if (!s1_on_q)  rgb_d = 8'd0;
    else if (s1_edge_q) rgb_d = GRID_RGB;
    else if (cell_hit)  rgb_d = SHIP_RGB;
    else                rgb_d = WATER_RGB;
  end

  assign bus.rgb     = rgb_q;
  assign bus.ship_px = ship_q;

endmodule

// File: tb/tb_vga_embarcacao_desenho.sv
module tb_vga_embarcacao_desenho;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_embarcacao_desenho_if bus();

  vga_embarcacao_desenho dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: {rgb, ship_px} expected for each issued pixel
  logic [8:0] exp_q[$];
  logic       px_req = 1'b0;
  logic       req_d1 = 1'b0;
  logic       req_d2 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel results appear two edges after the scan position is applied.
  always @(posedge clk) begin
    req_d1 <= px_req;
    req_d2 <= req_d1;
  end

  // Monitor
  always @(negedge clk) begin
    logic [8:0] e;
    if (req_d2) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pixel_unexpected: got output with no expectation at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("pixel_rgb", {56'd0, bus.rgb}, {56'd0, e[8:1]});
        check("pixel_ship", {63'd0, bus.ship_px}, {63'd0, e[0]});
      end
    end
  end

  // Driver tasks
  task automatic drive_px(input logic [9:0] x, input logic [9:0] y, input logic von,
                          input logic [7:0] er, input logic es);
    @(posedge clk); #1;
    bus.pixel_x  = x;
    bus.pixel_y  = y;
    bus.video_on = von;
    px_req       = 1'b1;
    exp_q.push_back({er, es});
  endtask

  task automatic px_idle();
    @(posedge clk); #1;
    px_req       = 1'b0;
    bus.video_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [63:0] v);
    @(posedge clk); #1;
    check("pos_ready_idle", {63'd0, bus.pos_ready}, 64'd1);
    bus.posicoesEmbarcacao = v;
    bus.pos_valid          = 1'b1;
    @(posedge clk); #1;
    bus.pos_valid          = 1'b0;
    bus.posicoesEmbarcacao = 64'd0;
  endtask

  // Walks the 8 BUILD cycles and lands in the first WAIT_SWAP cycle.
  task automatic build_wait(input logic early_fs);
    @(negedge clk);
    check("dup_clear_on_transfer", {63'd0, bus.dup_err}, 64'd0);
    check("pos_ready_busy", {63'd0, bus.pos_ready}, 64'd0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check("pos_ready_busy", {63'd0, bus.pos_ready}, 64'd0);
      if (i == 7 && early_fs) bus.frame_start = 1'b1;
    end
    @(negedge clk);
    bus.frame_start = 1'b0;
    check("pos_ready_wait", {63'd0, bus.pos_ready}, 64'd0);
    check("swap_not_early", {63'd0, bus.swap_done}, 64'd0);
  endtask

  task automatic do_swap();
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    @(negedge clk);
    check("swap_done_pulse", {63'd0, bus.swap_done}, 64'd1);
    check("pos_ready_after_swap", {63'd0, bus.pos_ready}, 64'd1);
    @(negedge clk);
    check("swap_done_drop", {63'd0, bus.swap_done}, 64'd0);
  endtask

  task automatic load_and_swap(input logic [63:0] v, input logic exp_dup);
    send_vec(v);
    build_wait(1'b0);
    check("dup_err_after_build", {63'd0, bus.dup_err}, {63'd0, exp_dup});
    do_swap();
  endtask

  initial begin
    bus.posicoesEmbarcacao = 64'd0;
    bus.pos_valid          = 1'b0;
    bus.frame_start        = 1'b0;
    bus.pixel_x            = 10'd0;
    bus.pixel_y            = 10'd0;
    bus.video_on           = 1'b0;

    // Reset values
    @(negedge clk);
    check("reset_rgb", {56'd0, bus.rgb}, 64'd0);
    check("reset_ship", {63'd0, bus.ship_px}, 64'd0);
    check("reset_dup", {63'd0, bus.dup_err}, 64'd0);
    check("reset_swap", {63'd0, bus.swap_done}, 64'd0);
    check("reset_ready", {63'd0, bus.pos_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Empty board before any vector
    drive_px(10'd200, 10'd100, 1'b1, 8'h03, 1'b0);
    px_idle();

    // Ship at X=2,Y=1 -> row 0, col 1
    load_and_swap(64'h12, 1'b0);
    drive_px(10'd200, 10'd100, 1'b1, 8'hE0, 1'b1);
    drive_px(10'd250, 10'd100, 1'b1, 8'h03, 1'b0);
    px_idle();

    // Same vector: grid, off-board and blanking cases
    load_and_swap(64'h12, 1'b0);
    drive_px(10'd192, 10'd100, 1'b1, 8'hFF, 1'b1);
    drive_px(10'd100, 10'd50,  1'b1, 8'h00, 1'b0);
    drive_px(10'd200, 10'd100, 1'b0, 8'h00, 1'b0);
    drive_px(10'd160, 10'd80,  1'b1, 8'hFF, 1'b0);
    drive_px(10'd159, 10'd100, 1'b1, 8'h00, 1'b0);
    drive_px(10'd480, 10'd100, 1'b1, 8'h00, 1'b0);
    drive_px(10'd479, 10'd100, 1'b1, 8'h03, 1'b0);
    drive_px(10'd200, 10'd400, 1'b1, 8'h00, 1'b0);
    px_idle();

    // Duplicate: slot0 = slot3 = X5,Y5 -> row 4, col 4
    load_and_swap(64'h00000000_55000055, 1'b1);
    drive_px(10'd298, 10'd218, 1'b1, 8'hE0, 1'b1);
    drive_px(10'd200, 10'd100, 1'b1, 8'h03, 1'b0);
    px_idle();
    load_and_swap(64'h12, 1'b0);

    // Invalid slots (Y=11, X=0): whole board is water at cell centres
    load_and_swap(64'h00000000_0030B300, 1'b0);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        drive_px(10'(176 + 32 * c), 10'(96 + 32 * r), 1'b1, 8'h03, 1'b0);
    drive_px(10'd192, 10'd112, 1'b1, 8'hFF, 1'b0);
    px_idle();

    // Vector A shown, vector B (X3,Y3 -> row 2,col 2) built but held back
    load_and_swap(64'h12, 1'b0);
    send_vec(64'h33);
    build_wait(1'b1);
    bus.posicoesEmbarcacao = 64'h44;
    bus.pos_valid          = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (i % 2 == 0) drive_px(10'd200, 10'd100, 1'b1, 8'hE0, 1'b1);
      else            drive_px(10'd240, 10'd160, 1'b1, 8'h03, 1'b0);
      if (i % 100 == 0) begin
        check("hold_pos_ready", {63'd0, bus.pos_ready}, 64'd0);
        check("hold_swap_done", {63'd0, bus.swap_done}, 64'd0);
      end
    end
    px_idle();
    bus.pos_valid          = 1'b0;
    bus.posicoesEmbarcacao = 64'd0;
    do_swap();
    drive_px(10'd240, 10'd160, 1'b1, 8'hE0, 1'b1);
    drive_px(10'd200, 10'd100, 1'b1, 8'h03, 1'b0);
    px_idle();

    // Reset in BUILD slot 4 with a duplicate already flagged
    bus.pixel_x  = 10'd240;
    bus.pixel_y  = 10'd160;
    bus.video_on = 1'b1;
    send_vec(64'h5555);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_reset_dup", {63'd0, bus.dup_err}, 64'd1);
    check("pre_reset_rgb", {56'd0, bus.rgb}, 64'hE0);
    reset = 1'b1;
    #1;
    check("async_rgb", {56'd0, bus.rgb}, 64'd0);
    check("async_ship", {63'd0, bus.ship_px}, 64'd0);
    check("async_dup", {63'd0, bus.dup_err}, 64'd0);
    check("async_swap", {63'd0, bus.swap_done}, 64'd0);
    check("async_ready", {63'd0, bus.pos_ready}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_px(10'd200, 10'd100, 1'b1, 8'h03, 1'b0);
    drive_px(10'd240, 10'd160, 1'b1, 8'h03, 1'b0);
    drive_px(10'd298, 10'd218, 1'b1, 8'h03, 1'b0);
    px_idle();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
